// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the three-sample majority vote used for bit decisions.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Reload counter producing a one-clock tick every DIV clocks.
// While clear is high the counter sits at 0, so the first tick after clear
// drops comes DIV clocks later and the tick phase follows the release.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic res_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clear && (cnt_q == LAST);

  // Count 0..DIV-1 and reload; held at 0 while cleared
  always_ff @(posedge clk) begin
    if (!res_n || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions,
// start/stop validation and a one-byte holding register.
//
// Handshake: valid high means data holds an unread byte; a transfer happens
// on every clock edge where valid && ready. data is stable while valid=1 and
// ready=0. valid drops after a transfer unless a new byte loads on that edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output rx_state_t  state_o
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx: CLK_FREQ must be at least 16*BAUD");
    end
  endgenerate

  logic       rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_t  state_q;
  logic [3:0] os_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] samp_q;
  logic [7:0] shift_q;
  logic       done_q;
  logic       frame_err_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       overrun_q;

  logic tick;
  logic fall;
  logic maj_mid;
  logic maj_stop;

  // Two-flop synchroniser plus previous-value flop for edge detection
  always_ff @(posedge clk) begin
    if (!res_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall = rxs_prev_q && !rxs_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .res_n (res_n),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  // Start/data decisions use the samples taken at os_cnt 7, 8 and 9. The stop
  // bit is decided on the os_cnt 9 tick itself, so its third sample is live.
  assign maj_mid  = majority3(samp_q[0], samp_q[1], samp_q[2]);
  assign maj_stop = majority3(samp_q[0], samp_q[1], rxs_q);

  // Receive FSM: frame timing, sampling, shifting and stop validation
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (fall) begin
          state_q   <= START;
          os_cnt_q  <= '0;
          bit_cnt_q <= '0;
        end
      end else if (tick) begin
        os_cnt_q <= os_cnt_q + 4'd1;
        if (os_cnt_q == 4'd7) samp_q[0] <= rxs_q;
        if (os_cnt_q == 4'd8) samp_q[1] <= rxs_q;
        if (os_cnt_q == 4'd9) samp_q[2] <= rxs_q;
        case (state_q)
          START: begin
            if (os_cnt_q == 4'd15) state_q <= maj_mid ? IDLE : DATA;
          end
          DATA: begin
            if (os_cnt_q == 4'd15) begin
              shift_q   <= {maj_mid, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= STOP;
            end
          end
          STOP: begin
            if (os_cnt_q == 4'd9) begin
              state_q <= IDLE;
              if (maj_stop) done_q <= 1'b1;
              else          frame_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: load completed bytes, flag overrun when full and unread
  always_ff @(posedge clk) begin
    if (!res_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign state_o   = state_q;

endmodule
